jam_cost_server: RTL and testbench



---
 rtl/jam_cost_if.sv | 34 +++
 rtl/jam_cost_server.sv | 183 ++++++++++++++++++
 tb/tb_jam_cost_server.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jam_cost_if.sv
// ============================================================================
// Module   : jam_cost_if
// Brief    : Load stream and search-engine lookup/result signals of the jam
//            cost server, with master (engine/loader) and slave (server) views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jam_cost_if #(
    parameter int COST_W = 7
);
    logic              ld_valid;
    logic              ld_ready;
    logic [COST_W-1:0] ld_data;
    logic              jam_rst;
    logic [2:0]        W;
    logic [2:0]        J;
    logic [COST_W-1:0] Cost;
    logic              Valid;
    logic [9:0]        MinCost;
    logic [3:0]        MatchCount;

    modport master (
        output ld_valid, ld_data, W, J, Valid, MinCost, MatchCount,
        input  ld_ready, jam_rst, Cost
    );

    modport slave (
        input  ld_valid, ld_data, W, J, Valid, MinCost, MatchCount,
        output ld_ready, jam_rst, Cost
    );
endinterface

`default_nettype wire

// File: rtl/jam_cost_server.sv
// ============================================================================
// Module   : jam_cost_server
// Brief    : Loads an 8x8 cost matrix, releases the search engine, serves
//            zero-latency cost lookups, captures the result; watchdog on SERVE.
//            Optional macro CYCLE_REPORT_EN adds res_cycles / overflow outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jam_cost_server #(
    parameter int          COST_W  = 7,
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    input  wire logic        clr,
    jam_cost_if.slave        bus,
    output logic             done,
    output logic             err,
    output logic [9:0]       res_min_cost,
    output logic [3:0]       res_match_count
`ifdef CYCLE_REPORT_EN
    ,
    output logic [19:0]      res_cycles,
    output logic             overflow
`endif
);

    localparam logic [1:0]  S_LOAD    = 2'd0;
    localparam logic [1:0]  S_RELEASE = 2'd1;
    localparam logic [1:0]  S_SERVE   = 2'd2;
    localparam logic [1:0]  S_DONE    = 2'd3;
    localparam logic [19:0] CNT_MAX   = 20'hFFFFF;

    logic [1:0]        state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [19:0]       cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              jam_rst_q, jam_rst_d;
    logic [9:0]        min_q, min_d;
    logic [3:0]        mc_q, mc_d;
    logic [COST_W-1:0] mem_q [64];

    logic              w_accept;
    logic              w_timeout;
    logic [19:0]       w_cnt_inc;

`ifdef CYCLE_REPORT_EN
    logic [19:0]       cyc_q, cyc_d;
    logic              ovf_q, ovf_d;
`endif

    // clr wins over a simultaneous load word, so a cleared cycle never writes
    assign w_accept  = (state_q == S_LOAD) && bus.ld_valid && !clr;
    assign w_cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 20'd1;
    assign w_timeout = (w_cnt_inc >= TIMEOUT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD:    if (w_accept && (idx_q == 6'd63)) state_d = S_RELEASE;
                S_RELEASE: state_d = S_SERVE;
                S_SERVE:   if (bus.Valid || w_timeout) state_d = S_DONE;
                S_DONE:    state_d = S_DONE;
                default:   state_d = S_LOAD;
            endcase
        end
    end

    always_comb begin
        bus.ld_ready = (state_q == S_LOAD);
        bus.jam_rst  = jam_rst_q;
        bus.Cost     = (state_q == S_SERVE) ? mem_q[{bus.W, bus.J}] : '0;
    end

    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        err_d     = err_q;
        min_d     = min_q;
        mc_d      = mc_q;
        jam_rst_d = (state_d != S_SERVE);
`ifdef CYCLE_REPORT_EN
        cyc_d     = cyc_q;
        ovf_d     = ovf_q;
`endif
        if (clr) begin
            idx_d  = 6'd0;
            cnt_d  = 20'd0;
            done_d = 1'b0;
            err_d  = 1'b0;
`ifdef CYCLE_REPORT_EN
            cyc_d  = 20'd0;
            ovf_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (w_accept) idx_d = idx_q + 6'd1;
                end
                S_RELEASE: begin
                    cnt_d = 20'd0;
                end
                S_SERVE: begin
                    cnt_d = w_cnt_inc;
                    // a result arriving on the timeout cycle still counts as success
                    if (bus.Valid) begin
                        done_d = 1'b1;
                        err_d  = 1'b0;
                        min_d  = bus.MinCost;
                        mc_d   = bus.MatchCount;
                    end else if (w_timeout) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
`ifdef CYCLE_REPORT_EN
                    if (w_cnt_inc == CNT_MAX) ovf_d = 1'b1;
                    if (bus.Valid || w_timeout) cyc_d = w_cnt_inc;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q     <= 6'd0;
            cnt_q     <= 20'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            jam_rst_q <= 1'b1;
            min_q     <= 10'd0;
            mc_q      <= 4'd0;
`ifdef CYCLE_REPORT_EN
            cyc_q     <= 20'd0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            jam_rst_q <= jam_rst_d;
            min_q     <= min_d;
            mc_q      <= mc_d;
`ifdef CYCLE_REPORT_EN
            cyc_q     <= cyc_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    // Matrix storage is deliberately left out of reset
    always_ff @(posedge CLK) begin
        if (w_accept) mem_q[idx_q] <= bus.ld_data;
    end

    assign done            = done_q;
    assign err             = err_q;
    assign res_min_cost    = min_q;
    assign res_match_count = mc_q;
`ifdef CYCLE_REPORT_EN
    assign res_cycles      = cyc_q;
    assign overflow        = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jam_cost_server.sv
// ============================================================================
// Module   : tb_jam_cost_server
// Brief    : Directed + randomized self-checking bench for jam_cost_server.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jam_cost_server;

    localparam int COST_W = 7;
`ifdef CYCLE_REPORT_EN
    localparam int TO_CYC = 250;
`else
    localparam int TO_CYC = 50;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        clr;
    logic        done;
    logic        err;
    logic [9:0]  res_min_cost;
    logic [3:0]  res_match_count;
`ifdef CYCLE_REPORT_EN
    logic [19:0] res_cycles;
    logic        overflow;
`endif

    jam_cost_if #(.COST_W(COST_W)) jif ();

    jam_cost_server #(
        .COST_W  (COST_W),
        .TIMEOUT (20'(TO_CYC))
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .clr             (clr),
        .bus             (jif.slave),
        .done            (done),
        .err             (err),
        .res_min_cost    (res_min_cost),
        .res_match_count (res_match_count)
`ifdef CYCLE_REPORT_EN
        ,
        .res_cycles      (res_cycles),
        .overflow        (overflow)
`endif
    );

    always #5 CLK = ~CLK;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [COST_W-1:0] model_mem [64];
    logic [9:0]        exp_min;
    logic [3:0]        exp_mc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ld_ready"}, 32'(jif.ld_ready), 1);
        chk({tag, "_jam_rst"},  32'(jif.jam_rst), 1);
        chk({tag, "_cost"},     32'(jif.Cost), 0);
        chk({tag, "_done"},     32'(done), 0);
        chk({tag, "_err"},      32'(err), 0);
        chk({tag, "_res_min"},  32'(res_min_cost), 0);
        chk({tag, "_res_mc"},   32'(res_match_count), 0);
`ifdef CYCLE_REPORT_EN
        chk({tag, "_res_cyc"},  res_cycles, 0);
        chk({tag, "_ovf"},      32'(overflow), 0);
`endif
    endtask

    // Feeds stop_after accepted words; the model stores only accepted words.
    task automatic load_matrix(input bit toggle, input bit rnd, input int stop_after);
        int                k   = 0;
        int                cyc = 0;
        bit                ph  = 1'b0;
        logic [COST_W-1:0] v;
        while (k < stop_after && cyc < 1000) begin
            ph = toggle ? ~ph : 1'b1;
            v  = rnd ? COST_W'($urandom_range(0, 127)) : COST_W'(k % 100);
            jif.ld_valid = ph;
            jif.ld_data  = ph ? v : COST_W'($urandom_range(0, 127));
            if (ph) begin
                chk("ld_ready_during_load", 32'(jif.ld_ready), 1);
                model_mem[k] = v;
                k++;
            end
            tick();
            cyc++;
        end
        jif.ld_valid = 1'b0;
        chk("load_count", k, stop_after);
    endtask

    // Called one edge after the 64th accept: RELEASE now, SERVE after next edge.
    task automatic post_load(input string tag);
        chk({tag, "_ready_drop"}, 32'(jif.ld_ready), 0);
        chk({tag, "_jam_rst_rel"}, 32'(jif.jam_rst), 1);
        tick();
        chk({tag, "_jam_rst_serve"}, 32'(jif.jam_rst), 0);
    endtask

    task automatic random_queries(input int n);
        for (int i = 0; i < n; i++) begin
            jif.W = 3'($urandom_range(0, 7));
            jif.J = 3'($urandom_range(0, 7));
            #1;
            chk("cost_query", 32'(jif.Cost), 32'(model_mem[{jif.W, jif.J}]));
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        clr = 1'b0;
        jif.ld_valid   = 1'b0;
        jif.ld_data    = '0;
        jif.W          = 3'd0;
        jif.J          = 3'd0;
        jif.Valid      = 1'b0;
        jif.MinCost    = 10'd0;
        jif.MatchCount = 4'd0;
        #3;
        check_reset("rst_async");
        tick();
        tick();
        RST = 1'b0;
        tick();
        check_reset("rst");

        load_matrix(1'b0, 1'b0, 64);
        post_load("load0");
        jif.W = 3'd5; jif.J = 3'd3; #1;
        chk("cost_w5j3", 32'(jif.Cost), 43);
        random_queries(16);

        jif.W = 3'd5; jif.J = 3'd3;
        jif.Valid = 1'b1; jif.MinCost = 10'd123; jif.MatchCount = 4'd2;
        tick();
        jif.Valid = 1'b0;
        chk("cap_done", 32'(done), 1);
        chk("cap_err", 32'(err), 0);
        chk("cap_min", 32'(res_min_cost), 123);
        chk("cap_mc", 32'(res_match_count), 2);
        chk("cap_jam_rst", 32'(jif.jam_rst), 1);
        chk("cap_cost0", 32'(jif.Cost), 0);
`ifdef CYCLE_REPORT_EN
        chk("cap_cycles", res_cycles, 1);
`endif
        jif.Valid = 1'b1; jif.MinCost = 10'd7; jif.MatchCount = 4'd9;
        tick();
        jif.Valid = 1'b0;
        chk("done_hold_min", 32'(res_min_cost), 123);
        chk("done_hold_mc", 32'(res_match_count), 2);
        chk("done_hold", 32'(done), 1);

        do_clr();
        chk("clr_done_ready", 32'(jif.ld_ready), 1);
        chk("clr_done_done", 32'(done), 0);
        chk("clr_done_err", 32'(err), 0);
        chk("clr_done_jam_rst", 32'(jif.jam_rst), 1);
        chk("clr_done_cost0", 32'(jif.Cost), 0);
`ifdef CYCLE_REPORT_EN
        chk("clr_done_cycles", res_cycles, 0);
`endif

        load_matrix(1'b1, 1'b1, 30);
        jif.ld_valid = 1'b1;
        do_clr();
        jif.ld_valid = 1'b0;
        chk("clr_load_ready", 32'(jif.ld_ready), 1);
        chk("clr_load_jam_rst", 32'(jif.jam_rst), 1);
        chk("clr_load_done", 32'(done), 0);
        load_matrix(1'b1, 1'b1, 64);
        post_load("reload");
        jif.W = 3'd7; jif.J = 3'd7; #1;
        chk("cost_w7j7", 32'(jif.Cost), 32'(model_mem[63]));
        random_queries(16);

        RST = 1'b1;
        #2;
        check_reset("rst_mid");
        tick();
        RST = 1'b0;
        tick();
        check_reset("rst_mid_after");

        load_matrix(1'b0, 1'b1, 64);
        post_load("to");
        repeat (TO_CYC - 1) tick();
        chk("to_not_yet", 32'(done), 0);
        tick();
        chk("to_done", 32'(done), 1);
        chk("to_err", 32'(err), 1);
        chk("to_res_min", 32'(res_min_cost), 0);
        chk("to_res_mc", 32'(res_match_count), 0);
        chk("to_jam_rst", 32'(jif.jam_rst), 1);
`ifdef CYCLE_REPORT_EN
        chk("to_cycles", res_cycles, TO_CYC);
        chk("to_ovf", 32'(overflow), 0);
`endif

        do_clr();
        load_matrix(1'b0, 1'b1, 64);
        post_load("race");
        repeat (TO_CYC - 1) tick();
        exp_min = 10'($urandom_range(0, 1023));
        exp_mc  = 4'($urandom_range(0, 15));
        jif.Valid = 1'b1; jif.MinCost = exp_min; jif.MatchCount = exp_mc;
        tick();
        jif.Valid = 1'b0;
        chk("race_done", 32'(done), 1);
        chk("race_err", 32'(err), 0);
        chk("race_min", 32'(res_min_cost), 32'(exp_min));
        chk("race_mc", 32'(res_match_count), 32'(exp_mc));

`ifdef CYCLE_REPORT_EN
        do_clr();
        load_matrix(1'b0, 1'b1, 64);
        post_load("cyc");
        repeat (199) tick();
        jif.Valid = 1'b1;
        tick();
        jif.Valid = 1'b0;
        chk("cyc200_cycles", res_cycles, 200);
        chk("cyc200_ovf", 32'(overflow), 0);
        chk("cyc200_done", 32'(done), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
